// File: rtl/match_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : MatchPkg
//  Description : Shared state encoding and width helpers for match_controller.
//  Revision    : 1.0  initial release
// ============================================================================
package MatchPkg;

    typedef enum logic [2:0] {
        S_START     = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_ROUND_END = 3'd3,
        S_WIN       = 3'd4,
        S_LOSE      = 3'd5,
        S_PAUSE     = 3'd6
    } state_e;

    function automatic int hp_width(input int hp_max);
        return $clog2(hp_max + 1);
    endfunction

    function automatic int win_width(input int rounds_to_win);
        return $clog2(rounds_to_win + 1);
    endfunction

    // Bits needed to hold any value in 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/match_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : match_controller_if
//  Description : Game-side flags in, match status out, for match_controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface match_controller_if #(
    parameter int HP_MAX        = 3,
    parameter int ROUNDS_TO_WIN = 2
);
    localparam int HP_W  = MatchPkg::hp_width(HP_MAX);
    localparam int WIN_W = MatchPkg::win_width(ROUNDS_TO_WIN);

    logic             i_select;
    logic             i_pause;
    logic             i_player_hit;
    logic             i_enemy_hit;
    logic             i_player_shield;
    logic             i_enemy_shield;
    logic [2:0]       o_state;
    logic             o_is_gaming;
    logic             o_round_start;
    logic [HP_W-1:0]  o_player_hp;
    logic [HP_W-1:0]  o_enemy_hp;
    logic [WIN_W-1:0] o_player_wins;
    logic [WIN_W-1:0] o_enemy_wins;
    logic             o_player_invuln;
    logic             o_enemy_invuln;

    modport master (
        output i_select, i_pause, i_player_hit, i_enemy_hit,
               i_player_shield, i_enemy_shield,
        input  o_state, o_is_gaming, o_round_start, o_player_hp, o_enemy_hp,
               o_player_wins, o_enemy_wins, o_player_invuln, o_enemy_invuln
    );

    modport slave (
        input  i_select, i_pause, i_player_hit, i_enemy_hit,
               i_player_shield, i_enemy_shield,
        output o_state, o_is_gaming, o_round_start, o_player_hp, o_enemy_hp,
               o_player_wins, o_enemy_wins, o_player_invuln, o_enemy_invuln
    );

endinterface
`default_nettype wire

// File: rtl/match_controller_fighter_status.sv
`default_nettype none
// ============================================================================
//  Module      : fighter_status
//  Description : Per-fighter HP, invulnerability frames and round-win count.
//  Revision    : 1.0  initial release
// ============================================================================
module fighter_status
    import MatchPkg::*;
#(
    parameter  int HP_MAX        = 3,
    parameter  int ROUNDS_TO_WIN = 2,
    parameter  int IFRAME_CYCLES = 4,
    localparam int HP_W          = hp_width(HP_MAX),
    localparam int WIN_W         = win_width(ROUNDS_TO_WIN)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             hit_i,
    input  wire logic             shield_i,
    input  wire logic             restore_hp_i,
    input  wire logic             clear_wins_i,
    input  wire logic             inc_win_i,
    input  wire logic             enable_damage_i,
    input  wire logic             clear_iframes_i,
    input  wire logic             freeze_iframes_i,
    output logic [HP_W-1:0]       hp_o,
    output logic [WIN_W-1:0]      wins_o,
    output logic                  invuln_o
);
    localparam int IF_W = cnt_width(IFRAME_CYCLES);

    logic [HP_W-1:0]  hp_q,     hp_d;
    logic [IF_W-1:0]  iframe_q, iframe_d;
    logic [WIN_W-1:0] wins_q,   wins_d;
    logic             damage;

    assign damage = enable_damage_i & hit_i & ~shield_i
                  & (iframe_q == '0) & (hp_q != '0);

    always_comb begin
        hp_d     = hp_q;
        iframe_d = iframe_q;
        wins_d   = wins_q;

        if (restore_hp_i) begin
            hp_d = HP_W'(HP_MAX);
        end else if (damage) begin
            hp_d = hp_q - HP_W'(1);
        end

        if (clear_iframes_i) begin
            iframe_d = '0;
        end else if (damage) begin
            iframe_d = IF_W'(IFRAME_CYCLES);
        end else if (!freeze_iframes_i && (iframe_q != '0)) begin
            iframe_d = iframe_q - IF_W'(1);
        end

        // Win count saturates so a stray increment can never wrap it.
        if (clear_wins_i) begin
            wins_d = '0;
        end else if (inc_win_i && (wins_q != WIN_W'(ROUNDS_TO_WIN))) begin
            wins_d = wins_q + WIN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_q     <= HP_W'(HP_MAX);
            iframe_q <= '0;
            wins_q   <= '0;
        end else begin
            hp_q     <= hp_d;
            iframe_q <= iframe_d;
            wins_q   <= wins_d;
        end
    end

    assign hp_o     = hp_q;
    assign wins_o   = wins_q;
    assign invuln_o = (iframe_q != '0);

endmodule
`default_nettype wire

// File: rtl/match_controller.sv
`default_nettype none
// ============================================================================
//  Module      : match_controller
//  Description : Best-of-N match FSM with countdown, HP and i-frames.
//                Optional pause state enabled by defining MATCH_PAUSE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module match_controller
    import MatchPkg::*;
#(
    parameter int HP_MAX           = 3,
    parameter int ROUNDS_TO_WIN    = 2,
    parameter int IFRAME_CYCLES    = 4,
    parameter int COUNTDOWN_CYCLES = 8,
    parameter int ROUND_END_CYCLES = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    match_controller_if.slave  bus
);
    localparam int HP_W    = hp_width(HP_MAX);
    localparam int WIN_W   = win_width(ROUNDS_TO_WIN);
    localparam int TMR_MAX = (COUNTDOWN_CYCLES > ROUND_END_CYCLES) ?
                             COUNTDOWN_CYCLES : ROUND_END_CYCLES;
    localparam int TMR_W   = cnt_width(TMR_MAX);
    localparam logic [TMR_W-1:0] CD_LOAD = TMR_W'(COUNTDOWN_CYCLES - 1);
    localparam logic [TMR_W-1:0] RE_LOAD = TMR_W'(ROUND_END_CYCLES - 1);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             round_start_q, round_start_d;
    logic             select_q;
    logic             sel_rise;
    logic             pause_rise;

    logic             restore_hp, clear_wins, enable_damage;
    logic             clear_iframes, freeze_iframes;
    logic             inc_player_win, inc_enemy_win;

    logic [HP_W-1:0]  player_hp, enemy_hp;
    logic [WIN_W-1:0] player_wins, enemy_wins;
    logic             player_invuln, enemy_invuln;

    assign sel_rise = bus.i_select & ~select_q;

`ifdef MATCH_PAUSE_EN
    logic pause_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_q <= 1'b0;
        end else begin
            pause_q <= bus.i_pause;
        end
    end

    assign pause_rise = bus.i_pause & ~pause_q;
`else
    logic unused_pause;
    assign unused_pause = bus.i_pause;
    assign pause_rise   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_START;
            timer_q       <= '0;
            round_start_q <= 1'b0;
            select_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            round_start_q <= round_start_d;
            select_q      <= bus.i_select;
        end
    end

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        round_start_d  = 1'b0;
        restore_hp     = 1'b0;
        clear_wins     = 1'b0;
        enable_damage  = 1'b0;
        clear_iframes  = 1'b0;
        freeze_iframes = 1'b0;
        inc_player_win = 1'b0;
        inc_enemy_win  = 1'b0;

        case (state_q)
            S_START: begin
                if (sel_rise) begin
                    clear_wins = 1'b1;
                    restore_hp = 1'b1;
                    timer_d    = CD_LOAD;
                    state_d    = S_COUNTDOWN;
                end
            end
            S_COUNTDOWN: begin
                if (timer_q == '0) begin
                    round_start_d = 1'b1;
                    state_d       = S_PLAY;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_PLAY: begin
                enable_damage = 1'b1;
                // Round outcome looks at registered HP: one cycle after the final hit.
                if ((player_hp == '0) || (enemy_hp == '0)) begin
                    inc_enemy_win  = (player_hp == '0) && (enemy_hp != '0);
                    inc_player_win = (enemy_hp == '0) && (player_hp != '0);
                    timer_d        = RE_LOAD;
                    state_d        = S_ROUND_END;
                end else if (pause_rise) begin
                    state_d = S_PAUSE;
                end
            end
            S_ROUND_END: begin
                clear_iframes = 1'b1;
                if (timer_q == '0) begin
                    if (player_wins == WIN_W'(ROUNDS_TO_WIN)) begin
                        state_d = S_WIN;
                    end else if (enemy_wins == WIN_W'(ROUNDS_TO_WIN)) begin
                        state_d = S_LOSE;
                    end else begin
                        restore_hp = 1'b1;
                        timer_d    = CD_LOAD;
                        state_d    = S_COUNTDOWN;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_WIN, S_LOSE: begin
                if (sel_rise) begin
                    state_d = S_START;
                end
            end
`ifdef MATCH_PAUSE_EN
            S_PAUSE: begin
                freeze_iframes = 1'b1;
                if (pause_rise) begin
                    state_d = S_PLAY;
                end
            end
`endif
            default: begin
                state_d = S_START;
            end
        endcase
    end

    fighter_status #(
        .HP_MAX        (HP_MAX),
        .ROUNDS_TO_WIN (ROUNDS_TO_WIN),
        .IFRAME_CYCLES (IFRAME_CYCLES)
    ) u_player (
        .clk              (clk),
        .rst_n            (rst_n),
        .hit_i            (bus.i_player_hit),
        .shield_i         (bus.i_player_shield),
        .restore_hp_i     (restore_hp),
        .clear_wins_i     (clear_wins),
        .inc_win_i        (inc_player_win),
        .enable_damage_i  (enable_damage),
        .clear_iframes_i  (clear_iframes),
        .freeze_iframes_i (freeze_iframes),
        .hp_o             (player_hp),
        .wins_o           (player_wins),
        .invuln_o         (player_invuln)
    );

    fighter_status #(
        .HP_MAX        (HP_MAX),
        .ROUNDS_TO_WIN (ROUNDS_TO_WIN),
        .IFRAME_CYCLES (IFRAME_CYCLES)
    ) u_enemy (
        .clk              (clk),
        .rst_n            (rst_n),
        .hit_i            (bus.i_enemy_hit),
        .shield_i         (bus.i_enemy_shield),
        .restore_hp_i     (restore_hp),
        .clear_wins_i     (clear_wins),
        .inc_win_i        (inc_enemy_win),
        .enable_damage_i  (enable_damage),
        .clear_iframes_i  (clear_iframes),
        .freeze_iframes_i (freeze_iframes),
        .hp_o             (enemy_hp),
        .wins_o           (enemy_wins),
        .invuln_o         (enemy_invuln)
    );

    assign bus.o_state         = state_q;
    assign bus.o_is_gaming     = (state_q == S_PLAY);
    assign bus.o_round_start   = round_start_q;
    assign bus.o_player_hp     = player_hp;
    assign bus.o_enemy_hp      = enemy_hp;
    assign bus.o_player_wins   = player_wins;
    assign bus.o_enemy_wins    = enemy_wins;
    assign bus.o_player_invuln = player_invuln;
    assign bus.o_enemy_invuln  = enemy_invuln;

endmodule
`default_nettype wire

// File: tb/tb_match_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_match_controller
//  Description : Cycle scoreboard bench for match_controller.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_match_controller;
    localparam int HP_MAX = 3;
    localparam int RTW    = 2;
    localparam int IFR    = 4;
    localparam int CD     = 8;
    localparam int RE     = 4;
`ifdef MATCH_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    typedef struct {
        int st; int gam; int rs; int php; int ehp;
        int pw; int ew; int pinv; int einv;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc_n = 0;

    int m_st, m_tmr, m_php, m_ehp, m_pw, m_ew, m_pif, m_eif, m_rs;
    bit m_selq, m_pseq;

    match_controller_if #(.HP_MAX(HP_MAX), .ROUNDS_TO_WIN(RTW)) bus ();

    match_controller #(
        .HP_MAX(HP_MAX), .ROUNDS_TO_WIN(RTW), .IFRAME_CYCLES(IFR),
        .COUNTDOWN_CYCLES(CD), .ROUND_END_CYCLES(RE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_tmr = 0; m_php = HP_MAX; m_ehp = HP_MAX; m_pw = 0; m_ew = 0;
        m_pif = 0; m_eif = 0; m_rs = 0; m_selq = 0; m_pseq = 0;
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.st = m_st; e.gam = (m_st == 2) ? 1 : 0; e.rs = m_rs;
        e.php = m_php; e.ehp = m_ehp; e.pw = m_pw; e.ew = m_ew;
        e.pinv = (m_pif != 0) ? 1 : 0; e.einv = (m_eif != 0) ? 1 : 0;
        return e;
    endfunction

    task automatic compare(input exp_t e, input string w);
        check_eq({w, ".state"},   32'(bus.o_state),         e.st);
        check_eq({w, ".gaming"},  32'(bus.o_is_gaming),     e.gam);
        check_eq({w, ".rstart"},  32'(bus.o_round_start),   e.rs);
        check_eq({w, ".p_hp"},    32'(bus.o_player_hp),     e.php);
        check_eq({w, ".e_hp"},    32'(bus.o_enemy_hp),      e.ehp);
        check_eq({w, ".p_wins"},  32'(bus.o_player_wins),   e.pw);
        check_eq({w, ".e_wins"},  32'(bus.o_enemy_wins),    e.ew);
        check_eq({w, ".p_inv"},   32'(bus.o_player_invuln), e.pinv);
        check_eq({w, ".e_inv"},   32'(bus.o_enemy_invuln),  e.einv);
    endtask

    // Reference behaviour of one clock edge, written from the game rules.
    task automatic model_step(input bit sel, input bit pse, input bit ph, input bit eh,
                              input bit ps, input bit es);
        int  ns = m_st, nt = m_tmr;
        bit  restore = 0, clri = 0, frz = 0;
        bit  srise = sel && !m_selq;
        bit  prise = PAUSE_EN && pse && !m_pseq;
        bit  pdmg  = (m_st == 2) && ph && !ps && (m_pif == 0) && (m_php > 0);
        bit  edmg  = (m_st == 2) && eh && !es && (m_eif == 0) && (m_ehp > 0);
        m_rs = 0;
        case (m_st)
            0: if (srise) begin ns = 1; nt = CD - 1; restore = 1; m_pw = 0; m_ew = 0; end
            1: if (m_tmr == 0) begin ns = 2; m_rs = 1; end else nt = m_tmr - 1;
            2: if (m_php == 0 || m_ehp == 0) begin
                   if (m_php == 0 && m_ehp != 0 && m_ew < RTW) m_ew++;
                   if (m_ehp == 0 && m_php != 0 && m_pw < RTW) m_pw++;
                   ns = 3; nt = RE - 1;
               end else if (prise) ns = 6;
            3: begin
                   clri = 1;
                   if (m_tmr != 0) nt = m_tmr - 1;
                   else if (m_pw == RTW) ns = 4;
                   else if (m_ew == RTW) ns = 5;
                   else begin restore = 1; ns = 1; nt = CD - 1; end
               end
            4, 5: if (srise) ns = 0;
            6: begin frz = 1; if (prise) ns = 2; end
            default: ns = 0;
        endcase
        m_pif = clri ? 0 : pdmg ? IFR : (frz || m_pif == 0) ? m_pif : m_pif - 1;
        m_eif = clri ? 0 : edmg ? IFR : (frz || m_eif == 0) ? m_eif : m_eif - 1;
        m_php = restore ? HP_MAX : pdmg ? m_php - 1 : m_php;
        m_ehp = restore ? HP_MAX : edmg ? m_ehp - 1 : m_ehp;
        m_st = ns; m_tmr = nt; m_selq = sel; m_pseq = pse;
    endtask

    task automatic cyc(input bit sel, input bit pse, input bit ph, input bit eh,
                       input bit ps, input bit es, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.i_select = sel; bus.i_pause = pse;
            bus.i_player_hit = ph; bus.i_enemy_hit = eh;
            bus.i_player_shield = ps; bus.i_enemy_shield = es;
            model_step(sel, pse, ph, eh, ps, es);
            sb.push_back(snap());
            @(posedge clk);
            #1;
            cyc_n++;
            e = sb.pop_front();
            compare(e, $sformatf("cyc%0d", cyc_n));
        end
    endtask

    task automatic idle(input int n);
        cyc(0, 0, 0, 0, 0, 0, n);
    endtask

    task automatic zero_inputs();
        bus.i_select = 0; bus.i_pause = 0; bus.i_player_hit = 0; bus.i_enemy_hit = 0;
        bus.i_player_shield = 0; bus.i_enemy_shield = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        zero_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare(snap(), "reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Match 1: select pulse, countdown, round won by player.
        cyc(1, 0, 0, 0, 0, 0, 1);
        idle(9);
        cyc(0, 0, 0, 1, 0, 0, 11);
        idle(14);
        // Round 2: shielded hits, simultaneous hits, then a draw.
        cyc(0, 0, 1, 0, 1, 0, 3);
        cyc(0, 0, 1, 1, 0, 0, 1);
        idle(5);
        cyc(0, 0, 1, 1, 0, 0, 1);
        idle(5);
        cyc(0, 0, 1, 1, 0, 0, 1);
        idle(14);
        // Round 3 with select held throughout: player takes the match.
        cyc(1, 0, 0, 1, 0, 0, 11);
        cyc(1, 0, 0, 0, 0, 0, 8);
        idle(2);
        cyc(1, 0, 0, 0, 0, 0, 1);
        idle(2);

        // Match 2: reach HP 1/2, wins 1/0, then reset mid-PLAY.
        cyc(1, 0, 0, 0, 0, 0, 1);
        idle(9);
        cyc(0, 0, 0, 1, 0, 0, 11);
        idle(14);
        cyc(0, 0, 1, 1, 0, 0, 1);
        idle(4);
        cyc(0, 0, 1, 0, 0, 0, 1);
        idle(1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        zero_inputs();
        #1;
        model_reset();
        compare(snap(), "async_rst");
        @(posedge clk);
        #1;
        compare(snap(), "rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Match 3: pause mid-i-frame (ignored when the pause build is off).
        cyc(1, 0, 0, 0, 0, 0, 1);
        idle(9);
        cyc(0, 0, 0, 1, 0, 0, 1);
        idle(1);
        cyc(0, 1, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 1, 0, 0, 3);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 1);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
